load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit for the RV32I core's memory stage: decodes a 12-bit byte address into a 2 KiB data memory, eleven 32-bit output peripheral registers and two 32-bit input ports. It performs byte/halfword/word stores and sign- or zero-extending loads. Loads return through a registered `rdata`; stores commit on the clock edge.

## Interface
Parameters: none; memory map fixed.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  12  byte address
- `wdata`  in  32  store data, lane-aligned from bit 0
- `wren`  in  1  store enable
- `rwsel`  in  3  access size/sign, RV32I funct3 encoding
- `sw`  in  32  switch inputs
- `btn`  in  32  button inputs
- `rdata`  out  32  load result
- `hex0`..`hex7`  out  32 each  seven-segment registers
- `ledr`, `ledg`  out  32 each  LED registers
- `lcd`  out  32  LCD register

## Operation
Memory map, decoded on `addr[11:4]` for I/O:
- 0x000–0x7FF: data memory, 512×32, word index `addr[10:2]`.
- 0x800 hex0, 0x810 hex1, 0x820 hex2, 0x830 hex3, 0x840 hex4, 0x850 hex5, 0x860 hex6, 0x870 hex7, 0x880 ledr, 0x890 ledg, 0x8A0 lcd.
- Each I/O register occupies a 16-byte window, so `addr[3:2]` is ignored.
- 0x900: `sw`, read-only.
- 0x910: `btn`, read-only.
- All other addresses: reads return 0, writes are ignored.

`rwsel` encoding:
- 000: byte, sign-extended load.
- 001: half, sign-extended load.
- 010: word.
- 100: byte, zero-extended load.
- 101: half, zero-extended load.
- 011, 110, 111: treated as word.

Lane rules:
- Word access ignores `addr[1:0]`, so unaligned word addresses round down.
- Half access selects its lane with `addr[1]` and ignores `addr[0]`.
- Byte access selects its lane with `addr[1:0]`.

Stores:
- Byte/half stores merge into the addressed word or register; untouched lanes are preserved. A byte-enable mask drives this merge.
- Stores to input ports or unmapped addresses have no effect.

Loads:
- Output peripheral registers are readable and return their current value.
- Inputs return the live value of `sw`/`btn` as sampled at the edge.

## Timing
- Store: commits at the rising edge where `wren`=1. Memory or register contents reflect it after that edge.
- Load: `rdata` is registered. It reflects the `addr`/`rwsel` present before a rising edge and is valid after that edge (1-cycle latency). `rdata` updates every cycle regardless of `wren`.
- Same-edge store and load to one word: `rdata` returns the old contents (read-before-write). The new value is visible one cycle later.
- Reset (`rst`=1 at an edge): clears `rdata`, `hex0`–`hex7`, `ledr`, `ledg` and `lcd` to 0. Data memory is not cleared. Reset has priority over a simultaneous store to a peripheral register; a simultaneous data-memory store still commits.

## Structure
- Shared package `lsu_pkg`:
  - `rwsel` encodings as named constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - Region base addresses.
  - Peripheral index constants.
- Sub-module `data_memory`, instance name `data_memory`:
  - 512×32 array named `mem`.
  - Synchronous write with 4-bit byte enable.
  - Synchronous read.
  - Lets the bench peek `data_memory.mem[addr/4]` by hierarchy.
- Top level contains:
  - Address decoder.
  - Byte-enable/lane shifting.
  - Peripheral register bank.
  - Load extender and the registered `rdata` mux.

## Test plan
- DMEM word round-trip: SW 0xDEADBEEF @0x124, then LW @0x124 → `rdata`=0xDEADBEEF one edge later. LW @0x127 → also 0xDEADBEEF. Repeat for 2048 random addresses in 0x000–0x7FF.
- Sub-word: SW 0x11223344 @0x040, SB 0xAA @0x041 → word becomes 0x1122AA44. Loads then return:
  - LB @0x041 → 0xFFFFFFAA.
  - LBU @0x041 → 0x000000AA.
  - LH @0x042 → 0x00001122.
  - LHU @0x040 → 0x0000AA44.
- Inputs: `sw`=0x12345678, LW @0x900 → 0x12345678. `btn`=0x0000000F, LW @0x910 → 0x0000000F. SW @0x900 leaves the read value unchanged.
- Outputs: SW random values to each of 0x800, 0x810, …, 0x8A0 → after the edge, `hex0`…`hex7`, `ledr`, `ledg`, `lcd` each equal the written value. LW back from each address returns the same value. SB 0x55 @0x803 sets `hex0[31:24]` only.
- Unmapped: SW 0xFFFFFFFF @0x8B0 and @0xA00 → all outputs unchanged; LW from either address → 0.
- Reset: write nonzero to all outputs, pulse `rst` for one edge → every output and `rdata` read 0. A previously written DMEM word still reads back intact afterwards.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: access encodings,
// memory-map bases, peripheral indices and the read-source/size types.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [11:0] DMEM_BASE = 12'h000;
  localparam logic [11:0] IO_BASE   = 12'h800;
  localparam logic [11:0] SW_ADDR   = 12'h900;
  localparam logic [11:0] BTN_ADDR  = 12'h910;

  localparam int NUM_PERIPH = 11;
  localparam int HEX0_IDX   = 0;
  localparam int HEX7_IDX   = 7;
  localparam int LEDR_IDX   = 8;
  localparam int LEDG_IDX   = 9;
  localparam int LCD_IDX    = 10;

  typedef enum logic [1:0] {SRC_NONE, SRC_DMEM, SRC_IO} rd_src_e;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;

  // Encodings 011, 110 and 111 fall through to a word access.
  function automatic size_e access_size(input logic [2:0] rwsel);
    case (rwsel[1:0])
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_data_memory.sv
// 512x32 data memory with byte-enabled synchronous write and synchronous
// read-before-write read port.
module data_memory (
  input  logic        clk,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        wren,
  output logic [31:0] rdata
);

  logic [31:0] mem [512];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (wren) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: address decode, lane steering, peripheral
// register bank and the load extender feeding a one-cycle-latency rdata.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic [2:0]  rwsel,
  input  logic [31:0] sw,
  input  logic [31:0] btn,
  output logic [31:0] rdata,
  output logic [31:0] hex0,
  output logic [31:0] hex1,
  output logic [31:0] hex2,
  output logic [31:0] hex3,
  output logic [31:0] hex4,
  output logic [31:0] hex5,
  output logic [31:0] hex6,
  output logic [31:0] hex7,
  output logic [31:0] ledr,
  output logic [31:0] ledg,
  output logic [31:0] lcd
);

  size_e       size;
  size_e       size_q;
  logic [3:0]  be;
  logic [31:0] mask;
  logic [31:0] wdata_lane;
  logic        is_dmem;
  logic        is_periph;
  logic        is_sw;
  logic        is_btn;
  logic [3:0]  periph_idx;
  logic [31:0] periph [NUM_PERIPH];
  logic [31:0] io_word;
  logic [31:0] io_q;
  logic [31:0] dmem_q;
  logic [31:0] raw_word;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  rd_src_e     src;
  rd_src_e     src_q;
  logic [1:0]  lane_q;
  logic        uns_q;

  assign is_dmem    = (addr[11] == DMEM_BASE[11]);
  assign periph_idx = addr[7:4];
  assign is_periph  = (addr[11:8] == IO_BASE[11:8]) && (periph_idx < 4'(NUM_PERIPH));
  assign is_sw      = (addr[11:4] == SW_ADDR[11:4]);
  assign is_btn     = (addr[11:4] == BTN_ADDR[11:4]);

  // Replicate store data into every lane; the byte enable picks the live one.
  always_comb begin
    size       = access_size(rwsel);
    be         = 4'b1111;
    wdata_lane = wdata;
    case (size)
      SIZE_BYTE: begin
        be         = 4'b0001 << addr[1:0];
        wdata_lane = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  data_memory data_memory (
    .clk   (clk),
    .addr  (addr[10:2]),
    .wdata (wdata_lane),
    .be    (be),
    .wren  (wren && is_dmem),
    .rdata (dmem_q)
  );

  always_comb begin
    src     = SRC_NONE;
    io_word = '0;
    if (is_dmem) begin
      src = SRC_DMEM;
    end else if (is_periph) begin
      src     = SRC_IO;
      io_word = periph[periph_idx];
    end else if (is_sw) begin
      src     = SRC_IO;
      io_word = sw;
    end else if (is_btn) begin
      src     = SRC_IO;
      io_word = btn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PERIPH; i++) periph[i] <= '0;
    end else if (wren && is_periph) begin
      periph[periph_idx] <= (periph[periph_idx] & ~mask) | (wdata_lane & mask);
    end
  end

  // Only flops feed rdata; clearing src_q on reset forces the load result to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= SRC_NONE;
      io_q   <= '0;
      lane_q <= '0;
      size_q <= SIZE_WORD;
      uns_q  <= 1'b0;
    end else begin
      src_q  <= src;
      io_q   <= io_word;
      lane_q <= addr[1:0];
      size_q <= size;
      uns_q  <= rwsel[2];
    end
  end

  always_comb begin
    case (src_q)
      SRC_DMEM: raw_word = dmem_q;
      SRC_IO:   raw_word = io_q;
      default:  raw_word = '0;
    endcase
    byte_val = raw_word[{lane_q, 3'b000} +: 8];
    half_val = raw_word[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      SIZE_BYTE: rdata = uns_q ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SIZE_HALF: rdata = uns_q ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
      default:   rdata = raw_word;
    endcase
  end

  assign hex0 = periph[HEX0_IDX];
  assign hex1 = periph[1];
  assign hex2 = periph[2];
  assign hex3 = periph[3];
  assign hex4 = periph[4];
  assign hex5 = periph[5];
  assign hex6 = periph[6];
  assign hex7 = periph[HEX7_IDX];
  assign ledr = periph[LEDR_IDX];
  assign ledg = periph[LEDG_IDX];
  assign lcd  = periph[LCD_IDX];

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed memory-map steps plus a
// randomized data-memory sweep against a byte-addressed reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wren = 1'b0;
  logic [2:0]  rwsel = LW;
  logic [31:0] sw = '0;
  logic [31:0] btn = '0;
  logic [31:0] rdata;
  logic [31:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, ledr, ledg, lcd;
  logic [31:0] outs [11];

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [2048];
  logic [31:0] ref_out [11];

  load_store_unit dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wren(wren), .rwsel(rwsel),
    .sw(sw), .btn(btn), .rdata(rdata),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .hex6(hex6), .hex7(hex7), .ledr(ledr), .ledg(ledg), .lcd(lcd)
  );

  always #5 clk = ~clk;

  always_comb begin
    outs[0] = hex0; outs[1] = hex1; outs[2] = hex2; outs[3] = hex3;
    outs[4] = hex4; outs[5] = hex5; outs[6] = hex6; outs[7] = hex7;
    outs[8] = ledr; outs[9] = ledg; outs[10] = lcd;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Little-endian byte memory: an n-byte access covers the naturally aligned
  // n-byte group containing the address.
  function automatic int access_bytes(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic void model_store(input logic [11:0] a, input logic [31:0] d, input logic [2:0] f);
    int n = access_bytes(f);
    int base = int'(a) & ~(n - 1);
    for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [11:0] a, input logic [2:0] f);
    int n = access_bytes(f);
    int base = int'(a) & ~(n - 1);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
    if (!f[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic apply_stimulus(input logic [11:0] a, input logic [31:0] d,
                                input logic we, input logic [2:0] f);
    addr  = a;
    wdata = d;
    wren  = we;
    rwsel = f;
    @(posedge clk);
    #1;
    wren = 1'b0;
    if (we && a < 12'h800) model_store(a, d, f);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [11:0] a;
    logic [11:0] la;
    logic [2:0]  f;
    logic [2:0]  f2;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("reset_rdata", rdata, 32'h0);
    for (int i = 0; i < 11; i++) check_output($sformatf("reset_out%0d", i), outs[i], 32'h0);

    $display("[TB] data memory word round-trip");
    apply_stimulus(12'h124, 32'h0000_0000, 1'b1, SW);
    apply_stimulus(12'h124, 32'hDEAD_BEEF, 1'b1, SW);
    check_output("rbw_old_value", rdata, 32'h0000_0000);
    apply_stimulus(12'h124, 32'h0, 1'b0, LW);
    check_output("lw_124", rdata, 32'hDEAD_BEEF);
    apply_stimulus(12'h127, 32'h0, 1'b0, LW);
    check_output("lw_127_unaligned", rdata, 32'hDEAD_BEEF);
    check_output("peek_mem_124", dut.data_memory.mem[9'h049], 32'hDEAD_BEEF);

    $display("[TB] sub-word accesses");
    apply_stimulus(12'h040, 32'h1122_3344, 1'b1, SW);
    apply_stimulus(12'h041, 32'h0000_00AA, 1'b1, SB);
    check_output("peek_mem_040", dut.data_memory.mem[9'h010], 32'h1122_AA44);
    apply_stimulus(12'h041, 32'h0, 1'b0, LB);
    check_output("lb_041", rdata, 32'hFFFF_FFAA);
    apply_stimulus(12'h041, 32'h0, 1'b0, LBU);
    check_output("lbu_041", rdata, 32'h0000_00AA);
    apply_stimulus(12'h042, 32'h0, 1'b0, LH);
    check_output("lh_042", rdata, 32'h0000_1122);
    apply_stimulus(12'h040, 32'h0, 1'b0, LHU);
    check_output("lhu_040", rdata, 32'h0000_AA44);
    apply_stimulus(12'h043, 32'h0000_BBCC, 1'b1, SH);
    apply_stimulus(12'h042, 32'h0, 1'b0, LH);
    check_output("lh_after_sh", rdata, 32'hFFFF_BBCC);

    $display("[TB] input ports");
    sw  = 32'h1234_5678;
    btn = 32'h0000_000F;
    apply_stimulus(12'h900, 32'h0, 1'b0, LW);
    check_output("lw_sw", rdata, 32'h1234_5678);
    apply_stimulus(12'h910, 32'h0, 1'b0, LW);
    check_output("lw_btn", rdata, 32'h0000_000F);
    apply_stimulus(12'h900, 32'hFFFF_FFFF, 1'b1, SW);
    apply_stimulus(12'h900, 32'h0, 1'b0, LW);
    check_output("sw_readonly", rdata, 32'h1234_5678);
    apply_stimulus(12'h903, 32'h0, 1'b0, LB);
    check_output("lb_sw_lane3", rdata, 32'h0000_0012);

    $display("[TB] output peripherals");
    for (int i = 0; i < 11; i++) begin
      ref_out[i] = $urandom | 32'h1;
      apply_stimulus(12'h800 + 12'(16 * i), ref_out[i], 1'b1, SW);
      check_output($sformatf("store_out%0d", i), outs[i], ref_out[i]);
    end
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(12'h80C + 12'(16 * i), 32'h0, 1'b0, LW);
      check_output($sformatf("load_out%0d", i), rdata, ref_out[i]);
    end
    apply_stimulus(12'h803, 32'h0000_0055, 1'b1, SB);
    ref_out[0] = {8'h55, ref_out[0][23:0]};
    check_output("sb_hex0_lane3", hex0, ref_out[0]);
    apply_stimulus(12'h852, 32'h0000_ABCD, 1'b1, SH);
    ref_out[5] = {16'hABCD, ref_out[5][15:0]};
    check_output("sh_hex5_upper", hex5, ref_out[5]);

    $display("[TB] unmapped addresses");
    apply_stimulus(12'h8B0, 32'hFFFF_FFFF, 1'b1, SW);
    apply_stimulus(12'hA00, 32'hFFFF_FFFF, 1'b1, SW);
    for (int i = 0; i < 11; i++) check_output($sformatf("unmapped_out%0d", i), outs[i], ref_out[i]);
    apply_stimulus(12'h8B0, 32'h0, 1'b0, LW);
    check_output("lw_8b0", rdata, 32'h0);
    apply_stimulus(12'hA00, 32'h0, 1'b0, LW);
    check_output("lw_a00", rdata, 32'h0);

    $display("[TB] randomized data memory sweep");
    for (int k = 0; k < 2048; k++) begin
      a  = 12'($urandom_range(0, 2047));
      f  = 3'($urandom_range(0, 7));
      f2 = 3'($urandom_range(0, 7));
      apply_stimulus(a, $urandom, 1'b1, SW);
      apply_stimulus(a ^ 12'($urandom_range(0, 3)), $urandom, 1'b1, f);
      la = {a[11:2], 2'($urandom_range(0, 3))};
      apply_stimulus(la, 32'h0, 1'b0, f2);
      check_output($sformatf("rand_load_%03h_f%0d", la, f2), rdata, model_load(la, f2));
    end

    $display("[TB] reset with pending stores");
    for (int i = 0; i < 11; i++) begin
      ref_out[i] = $urandom | 32'h1;
      apply_stimulus(12'h800 + 12'(16 * i), ref_out[i], 1'b1, SW);
    end
    apply_stimulus(12'h124, 32'hDEAD_BEEF, 1'b1, SW);
    rst = 1'b1;
    apply_stimulus(12'h810, 32'hCAFE_F00D, 1'b1, SW);
    check_output("reset_rdata_hex1_load", rdata, 32'h0);
    apply_stimulus(12'h300, 32'h0BAD_C0DE, 1'b1, SW);
    rst = 1'b0;
    check_output("reset_rdata_final", rdata, 32'h0);
    for (int i = 0; i < 11; i++) check_output($sformatf("reset2_out%0d", i), outs[i], 32'h0);
    apply_stimulus(12'h124, 32'h0, 1'b0, LW);
    check_output("dmem_kept_124", rdata, 32'hDEAD_BEEF);
    apply_stimulus(12'h300, 32'h0, 1'b0, LW);
    check_output("dmem_store_in_reset", rdata, model_load(12'h300, LW));
    check_output("peek_mem_300", dut.data_memory.mem[9'h0C0], 32'h0BAD_C0DE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
